// File: rtl/buffered_econet_tx_if.sv
// Host-side bus and serial line bundle for the buffered Econet transmitter.
// The slave modport is the transmitter; the master modport is the host/line side.
interface buffered_econet_tx_if #(
  parameter int ECO_CNTWIDTH = 9
);
  logic                    sys_wr;
  logic [ECO_CNTWIDTH-3:0] sys_addr;
  logic [3:0]              sys_be;
  logic [31:0]             sys_wdata;
  logic [ECO_CNTWIDTH-1:0] sys_len;
  logic                    sys_go;
  logic                    sys_abort;
  logic                    tx;
  logic                    tx_en;
  logic                    busy;
  logic                    done;
  logic                    aborted;

  modport master (
    output sys_wr, sys_addr, sys_be, sys_wdata, sys_len, sys_go, sys_abort,
    input  tx, tx_en, busy, done, aborted
  );

  modport slave (
    input  sys_wr, sys_addr, sys_be, sys_wdata, sys_len, sys_go, sys_abort,
    output tx, tx_en, busy, done, aborted
  );
endinterface

// File: rtl/buffered_econet_tx.sv
// Buffered Econet HDLC frame transmitter: flags, bit-stuffed payload, CRC-16/X.25 FCS.
// Define ECONET_TX_ABORT_EN to let sys_abort cut a frame short with eight 1s.
module buffered_econet_tx #(
  parameter int ECO_BUFSZ    = 512,
  parameter int ECO_CNTWIDTH = 9,
  parameter int LEAD_FLAGS   = 2
) (
  input  logic                 econet_clk,
  input  logic                 reset,
  buffered_econet_tx_if.slave  bus
);
  localparam int              WORDS     = ECO_BUFSZ / 4;
  localparam int              LW        = (LEAD_FLAGS > 1) ? $clog2(LEAD_FLAGS) : 1;
  localparam logic [LW-1:0]   LEAD_LAST = LW'(LEAD_FLAGS - 1);
  localparam logic [7:0]      FLAG      = 8'h7E;
  localparam logic [15:0]     POLY      = 16'h8408;

  typedef enum logic [2:0] {
    S_IDLE, S_LEAD, S_DATA, S_FCS, S_TAIL, S_ABRT
  } state_e;

  state_e                  state_q, state_d;
  logic [7:0]              sh_q, sh_d;
  logic [4:0]              bcnt_q, bcnt_d;
  logic [LW-1:0]           lead_q, lead_d;
  logic [ECO_CNTWIDTH-1:0] fidx_q, fidx_d;
  logic [ECO_CNTWIDTH-1:0] len_q, len_d;
  logic [15:0]             crc_q, crc_d;
  logic [2:0]              ones_q, ones_d;
  logic                    tx_q, en_q, done_q;
  logic                    bit_c, go_c, abort_c, fb_c;
  logic [7:0]              lane_c;

  logic [3:0][7:0]         mem_q [WORDS];
  logic [3:0][7:0]         rdata_q;

  // The word holding the next byte is re-read every cycle; fidx_q only moves
  // at byte boundaries, so rdata_q is settled long before it is consumed.
  always_ff @(posedge econet_clk) begin
    if (bus.sys_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.sys_be[i]) mem_q[bus.sys_addr][i] <= bus.sys_wdata[8*i +: 8];
      end
    end
    rdata_q <= mem_q[fidx_q[ECO_CNTWIDTH-1:2]];
  end

  assign lane_c = rdata_q[fidx_q[1:0]];
  assign go_c   = (state_q == S_IDLE) && !en_q && bus.sys_go;

`ifdef ECONET_TX_ABORT_EN
  logic aborted_q;

  assign abort_c = bus.sys_abort &&
                   (state_q == S_LEAD || state_q == S_DATA || state_q == S_FCS);

  always_ff @(posedge econet_clk or posedge reset) begin
    if (reset)        aborted_q <= 1'b0;
    else if (abort_c) aborted_q <= 1'b1;
    else if (go_c)    aborted_q <= 1'b0;
  end

  assign bus.aborted = aborted_q;
`else
  logic unused_abort;
  assign unused_abort = bus.sys_abort;
  assign abort_c      = 1'b0;
  assign bus.aborted  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bcnt_d  = bcnt_q;
    lead_d  = lead_q;
    fidx_d  = fidx_q;
    len_d   = len_q;
    crc_d   = crc_q;
    ones_d  = ones_q;
    bit_c   = 1'b1;
    fb_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (go_c) begin
          state_d = S_LEAD;
          len_d   = bus.sys_len;
          sh_d    = FLAG;
          bcnt_d  = '0;
          lead_d  = '0;
          fidx_d  = '0;
          crc_d   = 16'hFFFF;
          ones_d  = '0;
        end
      end
      S_LEAD: begin
        bit_c  = sh_q[0];
        sh_d   = sh_q >> 1;
        bcnt_d = bcnt_q + 5'd1;
        if (bcnt_q[2:0] == 3'd7) begin
          bcnt_d = '0;
          ones_d = '0;
          if (lead_q != LEAD_LAST) begin
            lead_d = lead_q + LW'(1);
            sh_d   = FLAG;
          end else if (len_q == '0) begin
            state_d = S_FCS;
          end else begin
            state_d = S_DATA;
            sh_d    = lane_c;
            fidx_d  = fidx_q + ECO_CNTWIDTH'(1);
          end
        end
      end
      S_DATA: begin
        if (ones_q == 3'd5) begin
          bit_c  = 1'b0;
          ones_d = '0;
        end else begin
          bit_c  = sh_q[0];
          fb_c   = crc_q[0] ^ sh_q[0];
          crc_d  = (crc_q >> 1) ^ (fb_c ? POLY : 16'h0000);
          ones_d = sh_q[0] ? ones_q + 3'd1 : 3'd0;
          sh_d   = sh_q >> 1;
          bcnt_d = bcnt_q + 5'd1;
          if (bcnt_q[2:0] == 3'd7) begin
            bcnt_d = '0;
            if (fidx_q == len_q) begin
              state_d = S_FCS;
            end else begin
              sh_d   = lane_c;
              fidx_d = fidx_q + ECO_CNTWIDTH'(1);
            end
          end
        end
      end
      S_FCS: begin
        // bcnt_q parks at 16 when the last FCS bit completes a run of five 1s,
        // so the closing stuffed 0 goes out before the flag.
        if (ones_q == 3'd5) begin
          bit_c  = 1'b0;
          ones_d = '0;
          if (bcnt_q == 5'd16) begin
            state_d = S_TAIL;
            bcnt_d  = '0;
            sh_d    = FLAG;
          end
        end else begin
          bit_c  = ~crc_q[0];
          crc_d  = crc_q >> 1;
          ones_d = bit_c ? ones_q + 3'd1 : 3'd0;
          bcnt_d = bcnt_q + 5'd1;
          if (bcnt_q == 5'd15 && ones_d != 3'd5) begin
            state_d = S_TAIL;
            bcnt_d  = '0;
            sh_d    = FLAG;
          end
        end
      end
      S_TAIL: begin
        bit_c  = sh_q[0];
        sh_d   = sh_q >> 1;
        bcnt_d = bcnt_q + 5'd1;
        if (bcnt_q[2:0] == 3'd7) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
        end
      end
      S_ABRT: begin
        bcnt_d = bcnt_q + 5'd1;
        if (bcnt_q == 5'd7) begin
          state_d = S_IDLE;
          bcnt_d  = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // The bit already on the line finishes; the first of the eight 1s follows.
    if (abort_c) begin
      state_d = S_ABRT;
      bit_c   = 1'b1;
      bcnt_d  = 5'd1;
    end
  end

  always_ff @(posedge econet_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      bcnt_q  <= '0;
      lead_q  <= '0;
      fidx_q  <= '0;
      len_q   <= '0;
      crc_q   <= 16'hFFFF;
      ones_q  <= '0;
      tx_q    <= 1'b1;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bcnt_q  <= bcnt_d;
      lead_q  <= lead_d;
      fidx_q  <= fidx_d;
      len_q   <= len_d;
      crc_q   <= crc_d;
      ones_q  <= ones_d;
      tx_q    <= bit_c;
      en_q    <= (state_q != S_IDLE);
      done_q  <= (state_q == S_IDLE) && en_q;
    end
  end

  assign bus.tx    = tx_q;
  assign bus.tx_en = en_q;
  assign bus.busy  = en_q;
  assign bus.done  = done_q;
endmodule

// File: tb/tb_buffered_econet_tx.sv
// Scoreboard bench for buffered_econet_tx: stimulus queues expected line bits per
// frame, a negedge monitor pops and compares them and checks receiver residue.
module tb_buffered_econet_tx;
  localparam int BUFSZ = 512;
  localparam int CW    = 9;
  localparam int LF    = 2;

  typedef struct {
    int nbits;
    int len;
    bit chk;
    bit abrt;
  } frame_t;

  logic econet_clk = 1'b0;
  logic reset      = 1'b1;

  buffered_econet_tx_if #(.ECO_CNTWIDTH(CW)) bus ();

  buffered_econet_tx #(
    .ECO_BUFSZ(BUFSZ), .ECO_CNTWIDTH(CW), .LEAD_FLAGS(LF)
  ) dut (
    .econet_clk(econet_clk),
    .reset     (reset),
    .bus       (bus)
  );

  always #5 econet_clk = ~econet_clk;

  int        vectors     = 0;
  int        miscompares = 0;
  logic [7:0] mbuf [BUFSZ];
  bit        exp_bits [$];
  frame_t    frames [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name, input int info);
    vectors++;
    miscompares++;
    $display("FAIL %s: info %0d", name, info);
  endtask

  task automatic push_raw(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) exp_bits.push_back(v[i]);
  endtask

  task automatic push_s(input bit b, inout int ones, inout int n);
    if (ones == 5) begin
      exp_bits.push_back(1'b0);
      n++;
      ones = 0;
    end
    exp_bits.push_back(b);
    n++;
    ones = b ? ones + 1 : 0;
  endtask

  task automatic push_frame(input int len, input bit chk_bits, input bit abrt);
    frame_t f;
    int ones = 0;
    int n = 0;
    logic [15:0] crc = 16'hFFFF;
    logic [7:0] b;
    if (chk_bits) begin
      for (int k = 0; k < LF; k++) push_raw(32'h7E, 8);
      n = 8 * LF;
      for (int i = 0; i < len; i++) begin
        b = mbuf[i];
        crc = crc ^ {8'h00, b};
        for (int j = 0; j < 8; j++) crc = crc[0] ? ((crc >> 1) ^ 16'h8408) : (crc >> 1);
        for (int j = 0; j < 8; j++) push_s(b[j], ones, n);
      end
      crc = ~crc;
      for (int j = 0; j < 16; j++) push_s(crc[j], ones, n);
      if (ones == 5) begin
        exp_bits.push_back(1'b0);
        n++;
      end
      push_raw(32'h7E, 8);
      n += 8;
    end
    f = '{n, len, chk_bits, abrt};
    frames.push_back(f);
  endtask

  task automatic wr(input int addr, input logic [3:0] be, input logic [31:0] d);
    bus.sys_wr    = 1'b1;
    bus.sys_addr  = addr[CW-3:0];
    bus.sys_be    = be;
    bus.sys_wdata = d;
    for (int i = 0; i < 4; i++) if (be[i]) mbuf[addr*4+i] = d[8*i +: 8];
    @(posedge econet_clk); #1;
    bus.sys_wr = 1'b0;
  endtask

  task automatic start(input int len);
    logic [CW-1:0] l;
    l = len[CW-1:0];
    bus.sys_len = l;
    bus.sys_go  = 1'b1;
    @(posedge econet_clk); #1;
    bus.sys_go  = 1'b0;
    bus.sys_len = l + 9'd5;
    chk("go_latency_tx_en", bus.tx_en, 0);
    chk("go_latency_busy", bus.busy, 0);
    chk("go_clears_aborted", bus.aborted, 0);
  endtask

  task automatic wait_done(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      @(negedge econet_clk);
      if (bus.done) break;
    end
    if (i == limit) flag_fail("done_timeout", limit);
  endtask

  // Monitor: acts like the receiver on the same clock.
  frame_t cur;
  bit     in_frame = 0;
  bit     done_low_chk = 0;
  int     cnt = 0;
  bit     rxq [$];
  bit     mon_eb;

  function automatic void rx_parse(output logic [15:0] crc, output int nb);
    int ones = 0;
    bit b;
    crc = 16'hFFFF;
    nb  = 0;
    for (int i = 8 * LF; i < rxq.size() - 8; i++) begin
      if (ones == 5) begin
        ones = 0;
        continue;
      end
      b = rxq[i];
      ones = b ? ones + 1 : 0;
      nb++;
      crc = (crc[0] ^ b) ? ((crc >> 1) ^ 16'h8408) : (crc >> 1);
    end
  endfunction

  task automatic end_frame();
    logic [15:0] res;
    int nb;
    logic [7:0] last8;
    chk("done_pulse", bus.done, 1);
    chk("busy_after_frame", bus.busy, 0);
    chk("tx_idle_high", bus.tx, 1);
    chk("aborted_flag", bus.aborted, cur.abrt);
    done_low_chk = 1;
    if (cur.chk) begin
      chk("frame_cycles", cnt, cur.nbits);
      for (int i = cnt; i < cur.nbits && exp_bits.size() > 0; i++) void'(exp_bits.pop_front());
    end
    if (cur.abrt) begin
      for (int i = 0; i < 8; i++) last8[i] = (rxq.size() > i) ? rxq[rxq.size()-1-i] : 1'b0;
      chk("abort_ones", last8, 8'hFF);
    end else begin
      rx_parse(res, nb);
      chk("rx_residue", res, 16'hF0B8);
      chk("rx_bitcount", nb, 8 * cur.len + 16);
    end
  endtask

  always @(negedge econet_clk) begin
    if (done_low_chk) begin
      chk("done_one_cycle", bus.done, 0);
      done_low_chk = 0;
    end
    if (reset) begin
      in_frame = 0;
      rxq.delete();
    end else if (bus.tx_en) begin
      if (!in_frame) begin
        in_frame = 1;
        cnt = 0;
        rxq.delete();
        if (frames.size() == 0) begin
          flag_fail("unexpected_frame", 0);
          cur = '{0, 0, 1'b0, 1'b0};
        end else begin
          cur = frames.pop_front();
        end
      end
      rxq.push_back(bus.tx);
      if (cur.chk && cnt < cur.nbits && exp_bits.size() > 0) begin
        mon_eb = exp_bits.pop_front();
        vectors++;
        if (bus.tx !== mon_eb) begin
          miscompares++;
          $display("FAIL line_bit[%0d]: got %b want %b", cnt, bus.tx, mon_eb);
        end
      end
      cnt++;
    end else if (in_frame) begin
      in_frame = 0;
      end_frame();
    end
  end

  initial begin
    bus.sys_wr = 0; bus.sys_addr = '0; bus.sys_be = '0; bus.sys_wdata = '0;
    bus.sys_len = '0; bus.sys_go = 0; bus.sys_abort = 0;
    repeat (3) @(posedge econet_clk);
    #1;
    chk("rst_tx", bus.tx, 1);
    chk("rst_tx_en", bus.tx_en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_aborted", bus.aborted, 0);
    reset = 0;
    @(posedge econet_clk); #1;

    // Empty frame: two flags, sixteen 0s of FCS, closing flag = 40 cycles.
    push_raw(32'h7E, 8); push_raw(32'h7E, 8); push_raw(32'h0, 16); push_raw(32'h7E, 8);
    frames.push_back('{40, 0, 1'b1, 1'b0});
    start(0);
    wait_done(200);

    // Single 0xFF: payload 11111 0 111, FCS 0xFF00 -> 8 zeros, 11111 0 111.
    wr(0, 4'b0001, 32'h000000FF);
    push_raw(32'h7E, 8); push_raw(32'h7E, 8);
    push_raw({6'h0, 3'b111, 1'b0, 5'b11111, 8'h00, 3'b111, 1'b0, 5'b11111}, 26);
    push_raw(32'h7E, 8);
    frames.push_back('{50, 1, 1'b1, 1'b0});
    start(1);
    wait_done(200);

    // 16-byte ramp assembled through mixed byte enables over stale data.
    for (int w = 0; w < 4; w++) wr(w, 4'hF, 32'hDEADBEEF);
    wr(0, 4'hF, 32'h03020100);
    wr(1, 4'b0011, 32'hAAAA0504);
    wr(1, 4'b1100, 32'h0706BBBB);
    wr(2, 4'b0001, 32'hCCCCCC08);
    wr(2, 4'b0010, 32'hCCCC09CC);
    wr(2, 4'b0100, 32'hCC0ACCCC);
    wr(2, 4'b1000, 32'h0BCCCCCC);
    wr(3, 4'b0101, 32'hEE0EEE0C);
    wr(3, 4'b1010, 32'h0FEE0DEE);
    push_frame(16, 1'b1, 1'b0);
    start(16);
    repeat (30) @(posedge econet_clk);
    #1;
    bus.sys_go = 1'b1; bus.sys_len = 9'd3;
    @(posedge econet_clk); #1;
    bus.sys_go = 1'b0;
    wait_done(600);

    // Back-to-back: go issued in the done cycle.
    push_frame(4, 1'b1, 1'b0);
    start(4);
    wait_done(300);

`ifdef ECONET_TX_ABORT_EN
    push_frame(16, 1'b0, 1'b1);
    start(16);
    repeat (30) @(posedge econet_clk);
    #1;
    bus.sys_abort = 1'b1;
    @(posedge econet_clk); #1;
    bus.sys_abort = 1'b0;
    wait_done(100);
    chk("aborted_sticky", bus.aborted, 1);
    push_frame(4, 1'b1, 1'b0);
    start(4);
    wait_done(300);
`else
    push_frame(16, 1'b1, 1'b0);
    start(16);
    repeat (30) @(posedge econet_clk);
    #1;
    bus.sys_abort = 1'b1;
    @(posedge econet_clk); #1;
    bus.sys_abort = 1'b0;
    wait_done(600);
`endif

    // Max frame: 511 bytes, byte i = i[7:0].
    for (int w = 0; w < BUFSZ / 4; w++)
      wr(w, 4'hF, {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
    push_frame(511, 1'b1, 1'b0);
    start(511);
    wait_done(6000);

    // Reset in the middle of DATA.
    push_frame(20, 1'b1, 1'b0);
    start(20);
    repeat (40) @(posedge econet_clk);
    #3;
    reset = 1'b1;
    exp_bits.delete();
    frames.delete();
    #1;
    chk("midrst_tx", bus.tx, 1);
    chk("midrst_tx_en", bus.tx_en, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_done", bus.done, 0);
    @(negedge econet_clk);
    @(negedge econet_clk);
    reset = 1'b0;
    @(posedge econet_clk); #1;
    chk("post_rst_busy", bus.busy, 0);
    wr(0, 4'hF, 32'h7E7EFF81);
    wr(1, 4'hF, 32'h00FF3CC3);
    push_frame(8, 1'b1, 1'b0);
    start(8);
    wait_done(300);

    repeat (3) @(negedge econet_clk);
    if (frames.size() != 0) flag_fail("frames_not_seen", frames.size());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
